// File: rtl/fetch_pkg.sv
// Shared types for the fetch/decode boundary.
// Slot bundle layout, lane count and thermometer helper.
package fetch_pkg;

  localparam int FETCH_LANES = 3;
  localparam int FETCH_DW    = 32;

  typedef struct packed {
    logic [FETCH_DW-1:0] instruction;
    logic [FETCH_DW-1:0] pc;
    logic [FETCH_DW-1:0] imm;
    logic                bp;
    logic [FETCH_DW-1:0] pc_at_prediction;
  } fetch_slot_t;

  function automatic logic [2:0] therm3(
    input logic [1:0] count
  );
    logic [2:0] t;
    unique case (count)
      2'd0:    t = 3'b000;
      2'd1:    t = 3'b001;
      2'd2:    t = 3'b011;
      default: t = 3'b111;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fetch_decode_latch.sv
// Compacting 3-entry latch between the instruction buffer and decode.
// Ports: buf_* offer (count/ready), dec_* take/valid, registered slot outputs.
module fetch_decode_latch
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic [2:0]            buf_valid_i,
  input  logic [DATA_WIDTH-1:0] buf_instruction_i_0,
  input  logic [DATA_WIDTH-1:0] buf_instruction_i_1,
  input  logic [DATA_WIDTH-1:0] buf_instruction_i_2,
  input  logic [DATA_WIDTH-1:0] buf_pc_i_0,
  input  logic [DATA_WIDTH-1:0] buf_pc_i_1,
  input  logic [DATA_WIDTH-1:0] buf_pc_i_2,
  input  logic [DATA_WIDTH-1:0] buf_imm_i_0,
  input  logic [DATA_WIDTH-1:0] buf_imm_i_1,
  input  logic [DATA_WIDTH-1:0] buf_imm_i_2,
  input  logic                  buf_bp_i_0,
  input  logic                  buf_bp_i_1,
  input  logic                  buf_bp_i_2,
  input  logic [DATA_WIDTH-1:0] buf_pc_pred_i_0,
  input  logic [DATA_WIDTH-1:0] buf_pc_pred_i_1,
  input  logic [DATA_WIDTH-1:0] buf_pc_pred_i_2,
  output logic [2:0]            buf_ready_o,
  output logic [2:0]            dec_valid_o,
  input  logic [1:0]            dec_take_i,
  output logic [DATA_WIDTH-1:0] instruction_o_0,
  output logic [DATA_WIDTH-1:0] instruction_o_1,
  output logic [DATA_WIDTH-1:0] instruction_o_2,
  output logic [DATA_WIDTH-1:0] pc_o_0,
  output logic [DATA_WIDTH-1:0] pc_o_1,
  output logic [DATA_WIDTH-1:0] pc_o_2,
  output logic [DATA_WIDTH-1:0] imm_o_0,
  output logic [DATA_WIDTH-1:0] imm_o_1,
  output logic [DATA_WIDTH-1:0] imm_o_2,
  output logic                  bp_o_0,
  output logic                  bp_o_1,
  output logic                  bp_o_2,
  output logic [DATA_WIDTH-1:0] pc_pred_o_0,
  output logic [DATA_WIDTH-1:0] pc_pred_o_1,
  output logic [DATA_WIDTH-1:0] pc_pred_o_2,
  output logic [1:0]            occupancy_o
);

  fetch_slot_t slot_q [FETCH_LANES];
  fetch_slot_t slot_n [FETCH_LANES];
  // 0..2 = held slots, 3..5 = offered buffer lanes
  fetch_slot_t cand   [6];

  logic [1:0] occ_q;
  logic [1:0] occ_n;
  logic [1:0] vld;
  logic [1:0] deq;
  logic [1:0] keep;
  logic [1:0] free;
  logic [1:0] enq;
  logic       kill;

  assign kill = reset | flush_i;

  always_comb begin
    cand[0] = slot_q[0];
    cand[1] = slot_q[1];
    cand[2] = slot_q[2];
    cand[3] = '{buf_instruction_i_0, buf_pc_i_0,
                buf_imm_i_0, buf_bp_i_0, buf_pc_pred_i_0};
    cand[4] = '{buf_instruction_i_1, buf_pc_i_1,
                buf_imm_i_1, buf_bp_i_1, buf_pc_pred_i_1};
    cand[5] = '{buf_instruction_i_2, buf_pc_i_2,
                buf_imm_i_2, buf_bp_i_2, buf_pc_pred_i_2};
  end

  always_comb begin
    vld  = (buf_valid_i > 3'd3) ? 2'd3 : buf_valid_i[1:0];
    deq  = (dec_take_i > occ_q) ? occ_q : dec_take_i;
    keep = occ_q - deq;
    // free = 3 - occ + deq; never exceeds 3 since deq <= occ
    free = 2'd3 - keep;
    enq  = kill ? 2'd0 : ((vld > free) ? free : vld);
    occ_n = kill ? 2'd0 : keep + enq;
  end

  // No path from buf_valid_i: ready depends only on state and take.
  assign buf_ready_o = kill ? 3'b000 : therm3(free);

  genvar j;
  for (j = 0; j < FETCH_LANES; j++) begin : g_slot
    logic       use_old;
    logic       use_new;
    logic [2:0] sel;

    assign use_old = !kill && (2'(j) < keep);
    assign use_new = !use_old && (2'(j) < occ_n);
    // survivors shift down by deq; new lanes stack right behind them
    assign sel = use_old ? 3'(j) + 3'(deq)
                         : 3'd3 + 3'(j) - 3'(keep);
    assign slot_n[j] = (use_old || use_new) ? cand[sel]
                     : CLEAR_PAYLOAD ? '0
                     : slot_q[j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= 2'd0;
      for (int i = 0; i < FETCH_LANES; i++)
        slot_q[i] <= CLEAR_PAYLOAD ? '0 : slot_q[i];
    end else begin
      occ_q <= occ_n;
      for (int i = 0; i < FETCH_LANES; i++)
        slot_q[i] <= slot_n[i];
    end
  end

  assign dec_valid_o = therm3(occ_q);
  assign occupancy_o = occ_q;

  assign instruction_o_0 = slot_q[0].instruction;
  assign instruction_o_1 = slot_q[1].instruction;
  assign instruction_o_2 = slot_q[2].instruction;
  assign pc_o_0          = slot_q[0].pc;
  assign pc_o_1          = slot_q[1].pc;
  assign pc_o_2          = slot_q[2].pc;
  assign imm_o_0         = slot_q[0].imm;
  assign imm_o_1         = slot_q[1].imm;
  assign imm_o_2         = slot_q[2].imm;
  assign bp_o_0          = slot_q[0].bp;
  assign bp_o_1          = slot_q[1].bp;
  assign bp_o_2          = slot_q[2].bp;
  assign pc_pred_o_0     = slot_q[0].pc_at_prediction;
  assign pc_pred_o_1     = slot_q[1].pc_at_prediction;
  assign pc_pred_o_2     = slot_q[2].pc_at_prediction;

endmodule

// File: tb/tb_fetch_decode_latch.sv
// Bench for fetch_decode_latch: directed scenarios plus random traffic
// checked against a queue-based model of the latch.
module tb_fetch_decode_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [2:0]  bvld;
  logic [1:0]  take;
  logic [31:0] in_ins [3];
  logic [31:0] in_pc  [3];
  logic [31:0] in_imm [3];
  logic        in_bp  [3];
  logic [31:0] in_pp  [3];

  logic [2:0]  rdy;
  logic [2:0]  dvld;
  logic [1:0]  occ;
  logic [31:0] o_ins [3];
  logic [31:0] o_pc  [3];
  logic [31:0] o_imm [3];
  logic        o_bp  [3];
  logic [31:0] o_pp  [3];

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        bp;
    logic [31:0] pp;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_decode_latch dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .buf_valid_i(bvld),
    .buf_instruction_i_0(in_ins[0]),
    .buf_instruction_i_1(in_ins[1]),
    .buf_instruction_i_2(in_ins[2]),
    .buf_pc_i_0(in_pc[0]), .buf_pc_i_1(in_pc[1]),
    .buf_pc_i_2(in_pc[2]),
    .buf_imm_i_0(in_imm[0]), .buf_imm_i_1(in_imm[1]),
    .buf_imm_i_2(in_imm[2]),
    .buf_bp_i_0(in_bp[0]), .buf_bp_i_1(in_bp[1]),
    .buf_bp_i_2(in_bp[2]),
    .buf_pc_pred_i_0(in_pp[0]), .buf_pc_pred_i_1(in_pp[1]),
    .buf_pc_pred_i_2(in_pp[2]),
    .buf_ready_o(rdy), .dec_valid_o(dvld), .dec_take_i(take),
    .instruction_o_0(o_ins[0]), .instruction_o_1(o_ins[1]),
    .instruction_o_2(o_ins[2]),
    .pc_o_0(o_pc[0]), .pc_o_1(o_pc[1]), .pc_o_2(o_pc[2]),
    .imm_o_0(o_imm[0]), .imm_o_1(o_imm[1]), .imm_o_2(o_imm[2]),
    .bp_o_0(o_bp[0]), .bp_o_1(o_bp[1]), .bp_o_2(o_bp[2]),
    .pc_pred_o_0(o_pp[0]), .pc_pred_o_1(o_pp[1]),
    .pc_pred_o_2(o_pp[2]),
    .occupancy_o(occ)
  );

  task automatic set_in(input logic [2:0] v, input logic [1:0] t,
                        input logic f, input logic r,
                        input logic [31:0] base);
    bvld  = v;
    take  = t;
    flush = f;
    reset = r;
    for (int i = 0; i < 3; i++) begin
      in_pc[i]  = base + 32'(4 * i);
      in_ins[i] = $urandom;
      in_imm[i] = $urandom;
      in_bp[i]  = 1'($urandom_range(0, 1));
      in_pp[i]  = $urandom;
    end
  endtask

  function automatic logic [2:0] exp_ready();
    int d;
    int fr;
    if (reset || flush) return 3'b000;
    d  = (int'(take) < q.size()) ? int'(take) : q.size();
    fr = 3 - q.size() + d;
    return 3'((1 << fr) - 1);
  endfunction

  // Advance the model with the inputs now applied, then clock.
  task automatic tick();
    int d;
    int n;
    if (reset || flush) begin
      q.delete();
    end else begin
      d = (int'(take) < q.size()) ? int'(take) : q.size();
      repeat (d) void'(q.pop_front());
      n = (bvld > 3'd3) ? 3 : int'(bvld);
      if (n > 3 - q.size()) n = 3 - q.size();
      for (int i = 0; i < n; i++)
        q.push_back('{in_ins[i], in_pc[i], in_imm[i],
                      in_bp[i], in_pp[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(3'd3, 2'd0, 1'b0, 1'b1, 32'h0);
    #1;
    checks++;
    if (rdy !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready got %b exp 000", rdy);
    end
    tick();
    set_in(3'd0, 2'd0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (occ !== 2'd0 || dvld !== 3'b000) begin
      errors++;
      $display("FAIL reset_state got occ=%0d v=%b exp 0/000",
               occ, dvld);
    end
    checks++;
    if ({o_pc[0], o_ins[2], o_imm[1]} !== 96'h0) begin
      errors++;
      $display("FAIL reset_payload got %h exp 0",
               {o_pc[0], o_ins[2], o_imm[1]});
    end
  endtask

  task automatic test_fill();
    set_in(3'd3, 2'd0, 1'b0, 1'b0, 32'h100);
    #1;
    checks++;
    if (rdy !== 3'b111) begin
      errors++;
      $display("FAIL fill_ready got %b exp 111", rdy);
    end
    tick();
    checks++;
    if (occ !== 2'd3 || dvld !== 3'b111) begin
      errors++;
      $display("FAIL fill_state got occ=%0d v=%b exp 3/111",
               occ, dvld);
    end
    checks++;
    if ({o_pc[0], o_pc[1], o_pc[2]} !==
        {32'h100, 32'h104, 32'h108}) begin
      errors++;
      $display("FAIL fill_pcs got %h %h %h exp 100 104 108",
               o_pc[0], o_pc[1], o_pc[2]);
    end
    set_in(3'd3, 2'd0, 1'b0, 1'b0, 32'h10C);
    #1;
    checks++;
    if (rdy !== 3'b000) begin
      errors++;
      $display("FAIL full_ready got %b exp 000", rdy);
    end
  endtask

  task automatic test_partial_take();
    set_in(3'd3, 2'd2, 1'b0, 1'b0, 32'h10C);
    #1;
    checks++;
    if (rdy !== 3'b011) begin
      errors++;
      $display("FAIL take2_ready got %b exp 011", rdy);
    end
    tick();
    checks++;
    if (occ !== 2'd3 ||
        {o_pc[0], o_pc[1], o_pc[2]} !==
        {32'h108, 32'h10C, 32'h110}) begin
      errors++;
      $display("FAIL take2_pcs got %0d %h %h %h exp 3 108 10c 110",
               occ, o_pc[0], o_pc[1], o_pc[2]);
    end
  endtask

  task automatic test_clamp();
    set_in(3'd0, 2'd0, 1'b0, 1'b1, 32'h0);
    tick();
    set_in(3'd1, 2'd0, 1'b0, 1'b0, 32'h200);
    tick();
    checks++;
    if (occ !== 2'd1 || o_pc[0] !== 32'h200) begin
      errors++;
      $display("FAIL clamp_setup got occ=%0d pc=%h exp 1 200",
               occ, o_pc[0]);
    end
    set_in(3'd0, 2'd3, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (rdy !== 3'b111) begin
      errors++;
      $display("FAIL clamp_ready got %b exp 111", rdy);
    end
    tick();
    checks++;
    if (occ !== 2'd0 || dvld !== 3'b000) begin
      errors++;
      $display("FAIL clamp_drain got occ=%0d v=%b exp 0/000",
               occ, dvld);
    end
  endtask

  task automatic test_flush();
    set_in(3'd2, 2'd0, 1'b0, 1'b0, 32'h300);
    tick();
    checks++;
    if (occ !== 2'd2 || dvld !== 3'b011) begin
      errors++;
      $display("FAIL flush_setup got occ=%0d v=%b exp 2/011",
               occ, dvld);
    end
    set_in(3'd3, 2'd2, 1'b1, 1'b0, 32'h400);
    #1;
    checks++;
    if (rdy !== 3'b000) begin
      errors++;
      $display("FAIL flush_ready got %b exp 000", rdy);
    end
    tick();
    checks++;
    if (occ !== 2'd0 ||
        {o_pc[0], o_pc[1], o_ins[0], o_pp[1]} !== 128'h0) begin
      errors++;
      $display("FAIL flush_clear got occ=%0d pc0=%h exp 0 0",
               occ, o_pc[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b;
    set_in(3'd3, 2'd0, 1'b0, 1'b0, 32'h1000);
    tick();
    for (int c = 0; c < 10; c++) begin
      b = 32'h100C + 32'(12 * c);
      set_in(3'd3, 2'd3, 1'b0, 1'b0, b);
      #1;
      checks++;
      if (rdy !== 3'b111) begin
        errors++;
        $display("FAIL b2b_ready c=%0d got %b exp 111", c, rdy);
      end
      tick();
      checks++;
      if (occ !== 2'd3 ||
          {o_pc[0], o_pc[1], o_pc[2]} !==
          {b, b + 32'd4, b + 32'd8}) begin
        errors++;
        $display("FAIL b2b_pcs c=%0d got %0d %h %h %h exp 3 %h",
                 c, occ, o_pc[0], o_pc[1], o_pc[2], b);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_in(3'd3, 2'd0, 1'b0, 1'b1, 32'h500);
    #1;
    checks++;
    if (rdy !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_ready got %b exp 000", rdy);
    end
    tick();
    set_in(3'd0, 2'd0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (occ !== 2'd0 || dvld !== 3'b000 ||
        {o_ins[0], o_ins[1], o_ins[2], o_pc[0], o_pc[1], o_pc[2],
         o_imm[0], o_imm[1], o_imm[2], o_bp[0], o_bp[1], o_bp[2],
         o_pp[0], o_pp[1], o_pp[2]} !== 387'h0) begin
      errors++;
      $display("FAIL rstmid_zero got occ=%0d pc0=%h exp all zero",
               occ, o_pc[0]);
    end
  endtask

  task automatic test_random();
    logic [128:0] got;
    logic [128:0] exp;
    set_in(3'd0, 2'd0, 1'b0, 1'b1, 32'h0);
    tick();
    for (int c = 0; c < 400; c++) begin
      set_in(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 31) == 0),
             $urandom & 32'hFFFF_FFFC);
      #1;
      checks++;
      if (rdy !== exp_ready()) begin
        errors++;
        $display("FAIL rnd_ready c=%0d got %b exp %b",
                 c, rdy, exp_ready());
      end
      tick();
      checks++;
      if (occ !== 2'(q.size()) ||
          dvld !== 3'((1 << q.size()) - 1)) begin
        errors++;
        $display("FAIL rnd_occ c=%0d got %0d/%b exp %0d",
                 c, occ, dvld, q.size());
      end
      for (int i = 0; i < 3; i++) begin
        got = {o_ins[i], o_pc[i], o_imm[i], o_bp[i], o_pp[i]};
        exp = '0;
        if (i < q.size())
          exp = {q[i].ins, q[i].pc, q[i].imm, q[i].bp, q[i].pp};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL rnd_lane%0d c=%0d got %h exp %h",
                   i, c, got, exp);
        end
      end
    end
  endtask

  initial begin
    set_in(3'd0, 2'd0, 1'b0, 1'b1, 32'h0);
    test_reset();
    test_fill();
    test_partial_take();
    test_clamp();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
